uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares the single TX FIFO write port of the `uart` block between `NUM_REQ` independent byte-stream requesters. Each requester presents messages as a valid/ready byte stream with a `last` marker. The grant is held for a whole message, so bytes of different requesters never interleave on the wire. The block sits between the requesters and `uart.i_tx_wr`/`i_tx_data`/`o_tx_full`, and caps the burst length so no requester can starve the others.

## Interface
- `DATA_WIDTH`, 8, byte width; matches `uart` `DATA_WIDTH`.
- `NUM_REQ`, 4, number of requesters (2..8).
- `MAX_BURST`, 16, maximum bytes accepted per grant before forced release (1..255).

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  NUM_REQ  per-requester byte valid.
- `i_req_data`  in  NUM_REQ*DATA_WIDTH  packed bytes; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `i_req_last`  in  NUM_REQ  marks the final byte of a message; qualified by valid.
- `o_req_ready`  out  NUM_REQ  byte accepted when valid & ready.
- `i_flush`  in  1  abort the current grant.
- `o_tx_wr`  out  1  write strobe to `uart.i_tx_wr`.
- `o_tx_data`  out  DATA_WIDTH  data to `uart.i_tx_data`.
- `i_tx_full`  in  1  from `uart.o_tx_full`.
- `o_grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `o_busy`  out  1  high in BURST.
- `o_trunc`  out  1  one-cycle pulse when a grant is released by the MAX_BURST cap.

## Operation
- There are two states, IDLE and BURST. Registered state: `grant_idx`, `ptr` (last served index), and `cnt` of width $clog2(MAX_BURST+1).
- **IDLE:**
  - The block scans `i_req_valid` starting at `(ptr+1) mod NUM_REQ` and picks the first requester with valid high.
  - On the next edge it loads `grant_idx`, clears `cnt` and enters BURST.
  - With no valid, it stays in IDLE.
  - `o_req_ready` is all zero in IDLE.
- **BURST:**
  - `o_req_ready[grant_idx] = !i_tx_full & !i_flush`; all other ready bits are 0.
  - A byte is accepted when `i_req_valid[grant_idx]` and ready are both high. On acceptance, `o_tx_wr = 1` and `o_tx_data` equals that requester's byte in the same cycle (combinational pass-through, no buffering).
  - Each accepted byte increments `cnt`.
  - If the accepted byte has `last`=1, the block goes to IDLE and sets `ptr <= grant_idx`.
  - Otherwise, if `cnt+1 == MAX_BURST`, the block goes to IDLE, sets `ptr <= grant_idx`, and pulses `o_trunc` in the following cycle.
  - If the granted requester drops valid, the grant is held, with no timeout.
- **Flush:** with `i_flush` high in any state, no byte is accepted that cycle. The next state is IDLE with `cnt` cleared; `ptr` is unchanged.
- **Fairness:** the requester just served has the lowest priority in the next arbitration.
- **Outputs:** `o_tx_wr` is never asserted while `i_tx_full` is high, so the TX FIFO overrun counter stays at 0.

## Timing
- Reset values: state IDLE, `ptr = NUM_REQ-1` (so requester 0 wins first), `grant_idx = 0`, `cnt = 0`, `o_grant = 0`, `o_busy = 0`, `o_trunc = 0`, `o_req_ready = 0`, `o_tx_wr = 0`, `o_tx_data = 0`.
- Arbitration latency: if valid rises in cycle N while IDLE, the grant is visible in N+1, and the first byte can be accepted in N+1.
- Throughput: 1 byte/cycle while the FIFO is not full. There is a one-cycle IDLE bubble between grants.
- Full back-pressure: ready drops in the same cycle `i_tx_full` rises, and accepts resume the cycle `i_tx_full` falls.
- `last` and the MAX_BURST cap hit in the same byte: treated as a normal `last`, no `o_trunc`.
- Reset asserted mid-burst: all outputs are forced to their reset values immediately (asynchronous). There is no partial-message recovery; the in-flight message is abandoned.

## Test plan
- **Single requester:** requester 0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), FIFO empty -> `o_grant = 0001` one cycle after valid. `o_tx_wr` is high for 3 consecutive cycles with the data in order, then `o_busy` = 0.
- **Round-robin:** all 4 requesters hold valid with 2-byte messages -> grant order 0,1,2,3,0. There is no interleaving of bytes within a message, and there is one idle cycle between grants.
- **Back-pressure:** force `i_tx_full` = 1 for 5 cycles mid-message -> `o_req_ready` = 0 and `o_tx_wr` = 0 throughout. The remaining bytes follow once full is released, and the overrun count stays 0.
- **Burst cap:** `MAX_BURST` = 16, requester 2 streams 20 bytes without last while requester 3 is valid -> 16 bytes accepted, then `o_trunc` pulses once, then requester 3 is granted. Requester 2 gets its remaining 4 bytes later.
- **Flush:** `i_flush` asserted after 2 of 5 bytes -> no write that cycle and the next state is IDLE. The same requester is re-granted first, because `ptr` is unchanged.
- **Loopback end-to-end:** connect to `uart` with `RX = TX`, `DIVISOR` = 13, `FRA_ADJ` = 2. Two requesters send 8 random bytes each -> RX FIFO reads 16 bytes, each message contiguous and in order, and `o_uart_rx_error` = 0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing the UART TX FIFO write port, message-granular with a burst cap.
module uart_tx_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]            i_req_last,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_flush,
   output logic                          o_tx_wr,
   output logic [DATA_WIDTH-1:0]         o_tx_data,
   input  logic                          i_tx_full,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic                          o_busy,
   output logic                          o_trunc
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t          state;
   logic [IW-1:0]   grant_idx, ptr, pick_idx;
   logic [CW-1:0]   cnt;
   logic            pick_ok, trunc, ready_g, accept, g_last;
   // Scan downward so the requester closest after ptr wins.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (i_req_valid[IW'((int'(ptr) + i) % NUM_REQ)]) begin
            pick_ok  = 1'b1;
            pick_idx = IW'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end
   assign ready_g     = (state == BURST) && !i_tx_full && !i_flush;
   assign accept      = ready_g && i_req_valid[grant_idx];
   assign g_last      = i_req_last[grant_idx];
   assign o_req_ready = ready_g ? (NUM_REQ'(1) << grant_idx) : '0;
   assign o_grant     = (state == BURST) ? (NUM_REQ'(1) << grant_idx) : '0;
   assign o_busy      = (state == BURST);
   assign o_tx_wr     = accept;
   assign o_tx_data   = accept ? i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign o_trunc     = trunc;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         ptr       <= IW'(NUM_REQ - 1);
         grant_idx <= '0;
         cnt       <= '0;
         trunc     <= 1'b0;
      end else begin
         trunc <= 1'b0;
         if (i_flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (pick_ok) begin
               state     <= BURST;
               grant_idx <= pick_idx;
               cnt       <= '0;
            end
         end else if (accept) begin
            cnt <= cnt + CW'(1);
            if (g_last || (cnt + CW'(1) == CW'(MAX_BURST))) begin
               state <= IDLE;
               ptr   <= grant_idx;
               trunc <= !g_last;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scenario tests for the round-robin TX arbiter.
module tb_uart_tx_arb;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [3:0]  i_req_valid = '0;
   logic [31:0] i_req_data = '0;
   logic [3:0]  i_req_last = '0;
   logic [3:0]  o_req_ready;
   logic        i_flush = 1'b0;
   logic        o_tx_wr;
   logic [7:0]  o_tx_data;
   logic        i_tx_full = 1'b0;
   logic [3:0]  o_grant;
   logic        o_busy;
   logic        o_trunc;
   int tests = 0;
   int fails = 0;
   int overrun = 0;
   logic [7:0] qd[4][$];
   logic       ql[4][$];
   bit         full_at[64];
   bit         flush_at[64];
   logic       tr_wr[64], tr_trunc[64], tr_busy[64];
   logic [7:0] tr_data[64];
   logic [3:0] tr_grant[64], tr_ready[64];
   uart_tx_arb #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
      .i_req_last(i_req_last), .o_req_ready(o_req_ready), .i_flush(i_flush), .o_tx_wr(o_tx_wr),
      .o_tx_data(o_tx_data), .i_tx_full(i_tx_full), .o_grant(o_grant), .o_busy(o_busy),
      .o_trunc(o_trunc)
   );
   always #5 i_clk = ~i_clk;
   task automatic push(input int k, input logic [7:0] d, input logic l);
      qd[k].push_back(d);
      ql[k].push_back(l);
   endtask
   task automatic do_reset();
      for (int k = 0; k < 4; k++) begin
         qd[k].delete();
         ql[k].delete();
      end
      for (int t = 0; t < 64; t++) begin
         full_at[t]  = 1'b0;
         flush_at[t] = 1'b0;
      end
      i_req_valid = '0;
      i_req_last  = '0;
      i_req_data  = '0;
      i_tx_full   = 1'b0;
      i_flush     = 1'b0;
      i_rst       = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask
   // One requester model step per cycle: drive queue heads, sample, pop accepted bytes.
   task automatic run(input int n);
      for (int t = 0; t < n; t++) begin
         @(negedge i_clk);
         i_tx_full = full_at[t];
         i_flush   = flush_at[t];
         for (int k = 0; k < 4; k++) begin
            i_req_valid[k] = qd[k].size() > 0;
            i_req_data[k*8 +: 8] = 8'h00;
            i_req_last[k] = 1'b0;
            if (qd[k].size() > 0) begin
               i_req_data[k*8 +: 8] = qd[k][0];
               i_req_last[k] = ql[k][0];
            end
         end
         #1;
         tr_wr[t]    = o_tx_wr;
         tr_data[t]  = o_tx_data;
         tr_grant[t] = o_grant;
         tr_ready[t] = o_req_ready;
         tr_trunc[t] = o_trunc;
         tr_busy[t]  = o_busy;
         if (o_tx_wr && i_tx_full) overrun++;
         for (int k = 0; k < 4; k++) begin
            if (i_req_valid[k] && o_req_ready[k]) begin
               void'(qd[k].pop_front());
               void'(ql[k].pop_front());
            end
         end
      end
   endtask
   task automatic test_reset();
      i_rst = 1'b1;
      #1;
      tests++;
      if ({o_grant, o_busy, o_trunc, o_req_ready, o_tx_wr, o_tx_data} !== 19'h0) begin
         fails++;
         $display("FAIL reset_outputs got %h exp 0", {o_grant, o_busy, o_trunc, o_req_ready, o_tx_wr, o_tx_data});
      end
   endtask
   task automatic test_single();
      logic [7:0] exp_d[3] = '{8'hA1, 8'hA2, 8'hA3};
      do_reset();
      push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
      run(5);
      tests++;
      if (tr_grant[0] !== 4'b0000 || tr_ready[0] !== 4'b0000 || tr_wr[0] !== 1'b0) begin
         fails++;
         $display("FAIL single_idle got grant %b ready %b wr %b exp 0", tr_grant[0], tr_ready[0], tr_wr[0]);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (tr_wr[1+i] !== 1'b1 || tr_data[1+i] !== exp_d[i] || tr_grant[1+i] !== 4'b0001) begin
            fails++;
            $display("FAIL single_byte%0d got wr %b data %h grant %b exp 1 %h 0001", i, tr_wr[1+i], tr_data[1+i], tr_grant[1+i], exp_d[i]);
         end
      end
      tests++;
      if (tr_busy[4] !== 1'b0 || tr_wr[4] !== 1'b0) begin
         fails++;
         $display("FAIL single_done got busy %b wr %b exp 0 0", tr_busy[4], tr_wr[4]);
      end
   endtask
   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_a[5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h05};
      logic [7:0] exp_b[5] = '{8'h02, 8'h12, 8'h22, 8'h32, 8'h06};
      do_reset();
      push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h05, 0); push(0, 8'h06, 1);
      push(1, 8'h11, 0); push(1, 8'h12, 1);
      push(2, 8'h21, 0); push(2, 8'h22, 1);
      push(3, 8'h31, 0); push(3, 8'h32, 1);
      run(15);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (tr_wr[3*i] !== 1'b0 || tr_busy[3*i] !== 1'b0) begin
            fails++;
            $display("FAIL rr_gap%0d got wr %b busy %b exp 0 0", i, tr_wr[3*i], tr_busy[3*i]);
         end
         tests++;
         if (tr_grant[3*i+1] !== 4'(1 << order[i]) || tr_grant[3*i+2] !== 4'(1 << order[i]) ||
             tr_data[3*i+1] !== exp_a[i] || tr_data[3*i+2] !== exp_b[i] || !tr_wr[3*i+1] || !tr_wr[3*i+2]) begin
            fails++;
            $display("FAIL rr_grant%0d got grant %b data %h %h exp grant %0d data %h %h",
                     i, tr_grant[3*i+1], tr_data[3*i+1], tr_data[3*i+2], order[i], exp_a[i], exp_b[i]);
         end
      end
   endtask
   task automatic test_back_pressure();
      do_reset();
      for (int i = 0; i < 6; i++) push(1, 8'h10 + 8'(i), i == 5);
      for (int t = 3; t < 8; t++) full_at[t] = 1'b1;
      overrun = 0;
      run(13);
      tests++;
      if (tr_ready[1] !== 4'b0010) begin
         fails++;
         $display("FAIL bp_ready got %b exp 0010", tr_ready[1]);
      end
      for (int t = 3; t < 8; t++) begin
         tests++;
         if (tr_ready[t] !== 4'b0000 || tr_wr[t] !== 1'b0 || tr_busy[t] !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall t=%0d got ready %b wr %b busy %b exp 0000 0 1", t, tr_ready[t], tr_wr[t], tr_busy[t]);
         end
      end
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (tr_wr[i < 2 ? 1 + i : 6 + i] !== 1'b1 || tr_data[i < 2 ? 1 + i : 6 + i] !== 8'h10 + 8'(i)) begin
            fails++;
            $display("FAIL bp_byte%0d got %h exp %h", i, tr_data[i < 2 ? 1 + i : 6 + i], 8'h10 + 8'(i));
         end
      end
      tests++;
      if (overrun !== 0 || tr_busy[12] !== 1'b0) begin
         fails++;
         $display("FAIL bp_overrun got %0d busy %b exp 0 0", overrun, tr_busy[12]);
      end
   endtask
   task automatic test_burst_cap();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 20; i++) push(2, 8'h20 + 8'(i), i == 19);
      push(3, 8'h40, 0); push(3, 8'h41, 1);
      run(26);
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (tr_wr[1+i] !== 1'b1 || tr_data[1+i] !== 8'h20 + 8'(i) || tr_grant[1+i] !== 4'b0100) begin
            fails++;
            $display("FAIL cap_byte%0d got %h grant %b exp %h 0100", i, tr_data[1+i], tr_grant[1+i], 8'h20 + 8'(i));
         end
      end
      for (int t = 0; t < 26; t++) pulses += int'(tr_trunc[t]);
      tests++;
      if (pulses !== 1 || tr_trunc[17] !== 1'b1 || tr_wr[17] !== 1'b0) begin
         fails++;
         $display("FAIL cap_trunc got pulses %0d trunc17 %b wr17 %b exp 1 1 0", pulses, tr_trunc[17], tr_wr[17]);
      end
      tests++;
      if (tr_grant[18] !== 4'b1000 || tr_data[18] !== 8'h40 || tr_data[19] !== 8'h41) begin
         fails++;
         $display("FAIL cap_next got grant %b data %h %h exp 1000 40 41", tr_grant[18], tr_data[18], tr_data[19]);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (tr_wr[21+i] !== 1'b1 || tr_data[21+i] !== 8'h30 + 8'(i) || tr_grant[21+i] !== 4'b0100) begin
            fails++;
            $display("FAIL cap_rest%0d got %h grant %b exp %h 0100", i, tr_data[21+i], tr_grant[21+i], 8'h30 + 8'(i));
         end
      end
      tests++;
      if (tr_busy[25] !== 1'b0) begin
         fails++;
         $display("FAIL cap_done got busy %b exp 0", tr_busy[25]);
      end
   endtask
   task automatic test_last_at_cap();
      int wr_cnt = 0;
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 16; i++) push(0, 8'h70 + 8'(i), i == 15);
      run(19);
      for (int t = 0; t < 19; t++) begin
         wr_cnt += int'(tr_wr[t]);
         pulses += int'(tr_trunc[t]);
      end
      tests++;
      if (wr_cnt !== 16 || pulses !== 0 || tr_busy[17] !== 1'b0 || tr_data[16] !== 8'h7F) begin
         fails++;
         $display("FAIL last_cap got writes %0d trunc %0d busy %b last %h exp 16 0 0 7f", wr_cnt, pulses, tr_busy[17], tr_data[16]);
      end
   endtask
   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) push(1, 8'h50 + 8'(i), i == 4);
      push(2, 8'h60, 1);
      flush_at[3] = 1'b1;
      run(10);
      tests++;
      if (tr_data[1] !== 8'h50 || tr_data[2] !== 8'h51 || tr_grant[1] !== 4'b0010) begin
         fails++;
         $display("FAIL flush_pre got %h %h grant %b exp 50 51 0010", tr_data[1], tr_data[2], tr_grant[1]);
      end
      tests++;
      if (tr_wr[3] !== 1'b0 || tr_ready[3] !== 4'b0000 || tr_busy[4] !== 1'b0) begin
         fails++;
         $display("FAIL flush_cycle got wr %b ready %b busy_next %b exp 0 0000 0", tr_wr[3], tr_ready[3], tr_busy[4]);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (tr_grant[5+i] !== 4'b0010 || tr_wr[5+i] !== 1'b1 || tr_data[5+i] !== 8'h52 + 8'(i)) begin
            fails++;
            $display("FAIL flush_regrant%0d got grant %b data %h exp 0010 %h", i, tr_grant[5+i], tr_data[5+i], 8'h52 + 8'(i));
         end
      end
      tests++;
      if (tr_grant[9] !== 4'b0100 || tr_data[9] !== 8'h60) begin
         fails++;
         $display("FAIL flush_after got grant %b data %h exp 0100 60", tr_grant[9], tr_data[9]);
      end
   endtask
   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) push(0, 8'h80 + 8'(i), i == 3);
      run(3);
      tests++;
      if (o_busy !== 1'b1) begin
         fails++;
         $display("FAIL arst_pre got busy %b exp 1", o_busy);
      end
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      tests++;
      if ({o_grant, o_busy, o_trunc, o_req_ready, o_tx_wr, o_tx_data} !== 19'h0) begin
         fails++;
         $display("FAIL arst_outputs got %h exp 0", {o_grant, o_busy, o_trunc, o_req_ready, o_tx_wr, o_tx_data});
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_burst_cap();
      test_last_at_cap();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
